// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the two
// requesters, the datapath ALU, the response consumer and alu_arbiter.
// The slave modport is the arbiter's view and the master modport is the
// environment's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             Valid0;
  logic [1:0]       Sel0;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic             Ready0;

  logic             Valid1;
  logic [1:0]       Sel1;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             Ready1;

  logic [1:0]       Alu_Sel;
  logic [WIDTH-1:0] Alu_A;
  logic [WIDTH-1:0] Alu_B;
  logic [WIDTH-1:0] Alu_Out;

  logic             Resp_Valid;
  logic             Resp_Id;
  logic [WIDTH-1:0] Resp_Data;
  logic             Resp_Ready;
  logic             Busy;

  modport slave (
    input  Valid0, Sel0, A0, B0,
    output Ready0,
    input  Valid1, Sel1, A1, B1,
    output Ready1,
    output Alu_Sel, Alu_A, Alu_B,
    input  Alu_Out,
    output Resp_Valid, Resp_Id, Resp_Data,
    input  Resp_Ready,
    output Busy
  );

  modport master (
    output Valid0, Sel0, A0, B0,
    input  Ready0,
    output Valid1, Sel1, A1, B1,
    input  Ready1,
    input  Alu_Sel, Alu_A, Alu_B,
    output Alu_Out,
    input  Resp_Valid, Resp_Id, Resp_Data,
    output Resp_Ready,
    input  Busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational datapath ALU between two requesters.
// IDLE arbitrates and latches the winner's operands, EXEC drives the ALU
// for a single cycle and captures its result, and RESP holds the result
// until the consumer takes it.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie and
// the round-robin pointer is not built. Default is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input logic          Clk,
  input logic          Reset,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       opSel_q, opSel_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             opId_q, opId_d;
  logic [WIDTH-1:0] respData_q, respData_d;
  logic             respId_q, respId_d;

  logic isIdle;
  logic isExec;
  logic grant0;
  logic grant1;

  assign isIdle = (state_q == IDLE);
  assign isExec = (state_q == EXEC);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 has strict priority; requester 1 only wins when 0 is idle.
  always_comb begin
    grant0 = isIdle && bus.Valid0;
    grant1 = isIdle && bus.Valid1 && !bus.Valid0;
  end
`else
  logic last_q, last_d;

  // Round-robin: on a tie the requester not served last time wins.
  always_comb begin
    grant0 = isIdle && bus.Valid0 && (!bus.Valid1 || last_q);
    grant1 = isIdle && bus.Valid1 && (!bus.Valid0 || !last_q);
  end

  // Pointer follows the most recent grant and sits at 1 after reset.
  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = 1'b0;
    end else if (grant1) begin
      last_d = 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state logic: latch operands on grant, capture the ALU in EXEC,
  // wait for the consumer in RESP.
  always_comb begin
    state_d    = state_q;
    opSel_d    = opSel_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opId_d     = opId_q;
    respData_d = respData_q;
    respId_d   = respId_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          opSel_d = bus.Sel0;
          opA_d   = bus.A0;
          opB_d   = bus.B0;
          opId_d  = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          opSel_d = bus.Sel1;
          opA_d   = bus.A1;
          opB_d   = bus.B1;
          opId_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        respData_d = bus.Alu_Out;
        respId_d   = opId_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.Resp_Ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      opSel_q    <= 2'b00;
      opA_q      <= '0;
      opB_q      <= '0;
      opId_q     <= 1'b0;
      respData_q <= '0;
      respId_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      opSel_q    <= opSel_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opId_q     <= opId_d;
      respData_q <= respData_d;
      respId_q   <= respId_d;
    end
  end

  assign bus.Ready0     = grant0;
  assign bus.Ready1     = grant1;
  assign bus.Alu_Sel    = isExec ? opSel_q : 2'b00;
  assign bus.Alu_A      = isExec ? opA_q : '0;
  assign bus.Alu_B      = isExec ? opB_q : '0;
  assign bus.Resp_Valid = (state_q == RESP);
  assign bus.Resp_Id    = respId_q;
  assign bus.Resp_Data  = respData_q;
  assign bus.Busy       = !isIdle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Stimulus pushes hand-computed responses into a
// scoreboard queue; a monitor pops and compares every accepted response.
module tb_alu_arbiter;

  logic Clk = 1'b0;
  logic Reset;

  int checks   = 0;
  int failures = 0;

  logic [16:0] expQ[$];

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock with a 10-unit period.
  always #5 Clk = ~Clk;

  // Reference ALU sitting on the datapath side.
  always_comb begin
    case (bus.Alu_Sel)
      2'b00:   bus.Alu_Out = bus.Alu_A;
      2'b01:   bus.Alu_Out = bus.Alu_A + bus.Alu_B;
      2'b10:   bus.Alu_Out = bus.Alu_A & bus.Alu_B;
      default: bus.Alu_Out = ~bus.Alu_A;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [1:0] sel,
                               input logic [15:0] a, input logic [15:0] b);
    if (id == 1'b0) begin
      bus.Valid0 = 1'b1;
      bus.Sel0   = sel;
      bus.A0     = a;
      bus.B0     = b;
    end else begin
      bus.Valid1 = 1'b1;
      bus.Sel1   = sel;
      bus.A1     = a;
      bus.B1     = b;
    end
  endtask

  // Waits (bounded) for a grant, checks who got it, returns just after the
  // accepting edge.
  task automatic waitGrant(input logic expId);
    int n = 0;
    @(negedge Clk);
    while (!(bus.Ready0 || bus.Ready1) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("grant_seen", {31'd0, bus.Ready0 || bus.Ready1}, 32'd1);
    checkOutput("grant_id", {30'd0, bus.Ready1, bus.Ready0},
                expId ? 32'd2 : 32'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge Clk);
      n++;
    end
    checkOutput("drain", expQ.size(), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  task automatic runOp(input logic id, input logic [1:0] sel,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expData);
    expQ.push_back({id, expData});
    applyStimulus(id, sel, a, b);
    waitGrant(id);
    if (id == 1'b0) bus.Valid0 = 1'b0;
    else bus.Valid1 = 1'b0;
    waitDrain();
  endtask

  // Scoreboard monitor: compares each response as it is handed over.
  initial begin
    logic [16:0] exp;
    forever begin
      @(negedge Clk);
      if (Reset && bus.Resp_Valid && bus.Resp_Ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", {15'd0, bus.Resp_Id, bus.Resp_Data},
                      32'hFFFF_FFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("resp_id", {31'd0, bus.Resp_Id}, {31'd0, exp[16]});
          checkOutput("resp_data", {16'd0, bus.Resp_Data}, {16'd0, exp[15:0]});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    bus.Valid0 = 1'b0; bus.Sel0 = 2'b00; bus.A0 = '0; bus.B0 = '0;
    bus.Valid1 = 1'b0; bus.Sel1 = 2'b00; bus.A1 = '0; bus.B1 = '0;
    bus.Resp_Ready = 1'b1;
    Reset = 1'b0;

    // Reset state.
    @(negedge Clk);
    checkOutput("rst_resp_valid", {31'd0, bus.Resp_Valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("rst_resp_data", {16'd0, bus.Resp_Data}, 32'd0);
    checkOutput("rst_resp_id", {31'd0, bus.Resp_Id}, 32'd0);
    checkOutput("rst_alu_sel", {30'd0, bus.Alu_Sel}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Single ADD with cycle-by-cycle latency and Busy checks.
    expQ.push_back({1'b0, 16'h8000});
    applyStimulus(1'b0, 2'b01, 16'h7FFF, 16'h0001);
    @(negedge Clk);
    checkOutput("single_ready0", {31'd0, bus.Ready0}, 32'd1);
    checkOutput("single_busy_idle", {31'd0, bus.Busy}, 32'd0);
    @(posedge Clk);
    #1;
    bus.Valid0 = 1'b0;
    @(negedge Clk);
    checkOutput("exec_busy", {31'd0, bus.Busy}, 32'd1);
    checkOutput("exec_ready0", {31'd0, bus.Ready0}, 32'd0);
    checkOutput("exec_alu", {14'd0, bus.Alu_Sel, bus.Alu_A}, {14'd0, 2'b01, 16'h7FFF});
    checkOutput("exec_alu_b", {16'd0, bus.Alu_B}, 32'h0001);
    @(negedge Clk);
    checkOutput("resp_valid", {31'd0, bus.Resp_Valid}, 32'd1);
    checkOutput("resp_busy", {31'd0, bus.Busy}, 32'd1);
    @(negedge Clk);
    checkOutput("done_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("done_resp_valid", {31'd0, bus.Resp_Valid}, 32'd0);
    waitDrain();

    // Wrapping ADD from requester 1.
    runOp(1'b1, 2'b01, 16'hFFFF, 16'h0002, 16'h0001);

    // Contention with both requesters held valid.
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      expQ.push_back({1'b0, 16'h00F0});
`else
      if (g % 2 == 0) expQ.push_back({1'b0, 16'h00F0});
      else expQ.push_back({1'b1, 16'hEDCB});
`endif
    end
    applyStimulus(1'b0, 2'b10, 16'hF0F0, 16'h0FF0);
    applyStimulus(1'b1, 2'b11, 16'h1234, 16'h5555);
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      waitGrant(1'b0);
`else
      waitGrant((g % 2) == 1);
`endif
    end
    bus.Valid0 = 1'b0;
    bus.Valid1 = 1'b0;
    waitDrain();

    // Backpressure: PASS held for 10 cycles while requester 1 waits.
    bus.Resp_Ready = 1'b0;
    expQ.push_back({1'b0, 16'hABCD});
    applyStimulus(1'b0, 2'b00, 16'hABCD, 16'h1111);
    waitGrant(1'b0);
    bus.Valid0 = 1'b0;
    expQ.push_back({1'b1, 16'hEDCB});
    applyStimulus(1'b1, 2'b11, 16'h1234, 16'h0000);
    @(negedge Clk);
    checkOutput("bp_exec_ready1", {31'd0, bus.Ready1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("bp_hold",
                  {11'd0, bus.Resp_Valid, bus.Resp_Id, bus.Ready0, bus.Ready1,
                   bus.Resp_Data},
                  {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD});
    end
    @(posedge Clk);
    #1;
    bus.Resp_Ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("bp_release_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("bp_release_ready1", {31'd0, bus.Ready1}, 32'd1);
    @(posedge Clk);
    #1;
    bus.Valid1 = 1'b0;
    waitDrain();

    // NOT with an ignored B operand.
    runOp(1'b0, 2'b11, 16'hABCD, 16'h1111, 16'h5432);

    // Reset in the middle of EXEC discards the operation.
    applyStimulus(1'b0, 2'b01, 16'h1111, 16'h2222);
    waitGrant(1'b0);
    bus.Valid0 = 1'b0;
    #3;
    Reset = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", {31'd0, bus.Resp_Valid}, 32'd0);
    checkOutput("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("midrst_alu",
                {14'd0, bus.Alu_Sel, bus.Alu_A} | {16'd0, bus.Alu_B}, 32'd0);
    applyStimulus(1'b0, 2'b10, 16'hF0F0, 16'h0FF0);
    applyStimulus(1'b1, 2'b11, 16'h1234, 16'h0000);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    expQ.push_back({1'b0, 16'h00F0});
    waitGrant(1'b0);
    bus.Valid0 = 1'b0;
    bus.Valid1 = 1'b0;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
